// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar scan scheduler.
package sonar_pkg;

    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] SONAR_NO_ECHO = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        ADVANCE
    } state_t;

endpackage

// File: rtl/sonar_cycle_timer.sv
// Clearable up-counter with an equality terminal-count flag.
module sonar_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         at_term_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign at_term_c = (count == term);

endmodule

// File: rtl/sonar_scan_sched.sv
// Round-robin scheduler sharing one ranging core across NUM_SENSORS transducers.
// Optional proximity alarm outputs are built when SONAR_PROX_ALARM_EN is defined.
module sonar_scan_sched
    import sonar_pkg::*;
#(
    parameter int unsigned NUM_SENSORS    = 4,
    parameter int unsigned GAP_CYCLES     = 120000,
    parameter int unsigned TIMEOUT_CYCLES = 80000,
    localparam int unsigned IDXW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   core_get_n,
    output logic                   core_rst_n,
    input  logic                   core_ready,
    input  logic [DATA_W-1:0]      core_data,
    output logic [IDXW-1:0]        sel,
    output logic                   result_valid,
    output logic [IDXW-1:0]        result_idx,
    output logic [DATA_W-1:0]      result_data,
    output logic                   result_timeout,
    input  logic [IDXW-1:0]        rd_idx,
    output logic [DATA_W-1:0]      rd_data,
`ifdef SONAR_PROX_ALARM_EN
    input  logic [DATA_W-1:0]      prox_thresh,
    output logic [NUM_SENSORS-1:0] prox_alarm,
`endif
    output logic                   busy
);

    localparam int unsigned TMAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t            state;
    state_t            state_d;
    logic [IDXW-1:0]   sel_d;
    logic              get_n_d;
    logic              rst_n_d;
    logic              capture;
    logic              timeout_hit;
    logic              wr_en;
    logic              timer_clr;
    logic              timer_done;
    logic [TW-1:0]     timer_term;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] dist_tbl [NUM_SENSORS];

    // One counter serves both the echo timeout and the quiet gap.
    assign timer_term = (state == GAP) ? TW'(GAP_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);

    sonar_cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (timer_clr),
        .term      (timer_term),
        .at_term_c (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        sel_d       = sel;
        get_n_d     = 1'b1;
        rst_n_d     = 1'b1;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        timer_clr   = 1'b1;
        case (state)
            IDLE: begin
                if (enable) state_d = START;
            end
            START: begin
                get_n_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // A ready on the terminal cycle still counts as a good echo.
                if (core_ready) begin
                    capture = 1'b1;
                    state_d = GAP;
                end else if (timer_done) begin
                    timeout_hit = 1'b1;
                    rst_n_d     = 1'b0;
                    state_d     = GAP;
                end else begin
                    timer_clr = 1'b0;
                end
            end
            GAP: begin
                if (timer_done) state_d = ADVANCE;
                else            timer_clr = 1'b0;
            end
            ADVANCE: begin
                sel_d   = (sel == IDXW'(NUM_SENSORS - 1)) ? '0 : sel + IDXW'(1);
                state_d = enable ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en   = capture | timeout_hit;
    assign wr_data = capture ? core_data : SONAR_NO_ECHO;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel            <= '0;
            core_get_n     <= 1'b1;
            core_rst_n     <= 1'b0;
            result_valid   <= 1'b0;
            result_idx     <= '0;
            result_data    <= '0;
            result_timeout <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sel          <= sel_d;
            core_get_n   <= get_n_d;
            core_rst_n   <= rst_n_d;
            result_valid <= wr_en;
            busy         <= (state_d != IDLE);
            if (wr_en) begin
                result_idx     <= sel;
                result_data    <= wr_data;
                result_timeout <= timeout_hit;
            end
        end
    end

    // Distance table; a same-cycle read of the written entry returns the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
                dist_tbl[i] <= SONAR_NO_ECHO;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) dist_tbl[sel] <= wr_data;
            if (32'(rd_idx) < NUM_SENSORS) rd_data <= dist_tbl[rd_idx];
            else                           rd_data <= SONAR_NO_ECHO;
        end
    end

`ifdef SONAR_PROX_ALARM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            prox_alarm <= '0;
        end else if (wr_en) begin
            prox_alarm[sel] <= capture && (core_data < prox_thresh);
        end
    end
`endif

endmodule

// File: tb/tb_sonar_scan_sched.sv
// Directed bench for sonar_scan_sched (3 sensors, gap 10, timeout 50).
// Covers the SONAR_PROX_ALARM_EN build as well when that macro is defined.
module tb_sonar_scan_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        core_get_n;
    logic        core_rst_n;
    logic        core_ready;
    logic [15:0] core_data;
    logic [1:0]  sel;
    logic        result_valid;
    logic [1:0]  result_idx;
    logic [15:0] result_data;
    logic        result_timeout;
    logic [1:0]  rd_idx;
    logic [15:0] rd_data;
    logic        busy;
`ifdef SONAR_PROX_ALARM_EN
    logic [15:0] prox_thresh;
    logic [2:0]  prox_alarm;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sonar_scan_sched #(
        .NUM_SENSORS    (3),
        .GAP_CYCLES     (10),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .core_get_n     (core_get_n),
        .core_rst_n     (core_rst_n),
        .core_ready     (core_ready),
        .core_data      (core_data),
        .sel            (sel),
        .result_valid   (result_valid),
        .result_idx     (result_idx),
        .result_data    (result_data),
        .result_timeout (result_timeout),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
`ifdef SONAR_PROX_ALARM_EN
        .prox_thresh    (prox_thresh),
        .prox_alarm     (prox_alarm),
`endif
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sel"},      32'(sel), 0);
        check({tag, "_get_n"},    32'(core_get_n), 1);
        check({tag, "_core_rst"}, 32'(core_rst_n), 0);
        check({tag, "_valid"},    32'(result_valid), 0);
        check({tag, "_idx"},      32'(result_idx), 0);
        check({tag, "_data"},     32'(result_data), 0);
        check({tag, "_tmo"},      32'(result_timeout), 0);
        check({tag, "_rd"},       32'(rd_data), 0);
        check({tag, "_busy"},     32'(busy), 0);
`ifdef SONAR_PROX_ALARM_EN
        check({tag, "_alarm"},    32'(prox_alarm), 0);
`endif
    endtask

    // Negedges until core_get_n is seen low, capped at max.
    task automatic wait_get_low(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (core_get_n !== 1'b0 && n < max);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (result_valid !== 1'b1 && n < max);
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < max);
    endtask

    // Entered on the first WAIT cycle; leaves two cycles into GAP.
    task automatic run_slot(input logic [1:0] exp_sel, input bit respond, input logic [15:0] d);
        int n;
        logic [15:0] exp_data;
        exp_data = respond ? d : 16'hFFFF;
        check("slot_sel", 32'(sel), 32'(exp_sel));
        check("slot_busy", 32'(busy), 1);
        @(negedge clk);
        check("get_pulse_width", 32'(core_get_n), 1);
        if (respond) begin
            repeat (18) @(negedge clk);
            check("no_early_valid", 32'(result_valid), 0);
            core_ready = 1'b1;
            core_data  = d;
            @(negedge clk);
            core_ready = 1'b0;
            check("echo_valid", 32'(result_valid), 1);
            check("echo_tmo", 32'(result_timeout), 0);
            check("echo_core_rst", 32'(core_rst_n), 1);
        end else begin
            wait_valid(60, n);
            check("timeout_len", 32'(n), 49);
            check("timeout_tmo", 32'(result_timeout), 1);
            check("timeout_core_rst", 32'(core_rst_n), 0);
        end
        check("result_idx", 32'(result_idx), 32'(exp_sel));
        check("result_data", 32'(result_data), 32'(exp_data));
`ifdef SONAR_PROX_ALARM_EN
        check("alarm_bit", 32'(prox_alarm[exp_sel]), 32'(respond && (d < 16'h0200)));
`endif
        @(negedge clk);
        check("valid_pulse", 32'(result_valid), 0);
        check("core_rst_pulse", 32'(core_rst_n), 1);
        core_ready = 1'b1;
        core_data  = 16'h0BAD;
        @(negedge clk);
        core_ready = 1'b0;
        check("gap_ready_ignored", 32'(result_valid), 0);
        check("result_hold", 32'(result_data), 32'(exp_data));
    endtask

    initial begin
        int n;
        bit seen_get;
        reset      = 1'b0;
        enable     = 1'b0;
        core_ready = 1'b0;
        core_data  = '0;
        rd_idx     = '0;
`ifdef SONAR_PROX_ALARM_EN
        prox_thresh = 16'h0200;
`endif
        repeat (2) @(negedge clk);
        check_reset("rst");

        reset  = 1'b1;
        enable = 1'b1;
        wait_get_low(10, n);
        check("first_get_lat", 32'(n), 2);
        check("core_rst_release", 32'(core_rst_n), 1);

        run_slot(2'd0, 1'b1, 16'h0123);
        wait_get_low(20, n);
        check("slot_period", 32'(n), 10);
        run_slot(2'd1, 1'b1, 16'h0150);
        wait_get_low(20, n);
        check("slot_period", 32'(n), 10);
        run_slot(2'd2, 1'b0, 16'h0000);
        wait_get_low(20, n);
        check("slot_period", 32'(n), 10);
        run_slot(2'd0, 1'b0, 16'h0000);
        wait_get_low(20, n);
        check("slot_period", 32'(n), 10);

        // Sensor 1 again: drop enable mid-WAIT and read the table meanwhile.
        check("slot4_sel", 32'(sel), 1);
        enable = 1'b0;
        rd_idx = 2'd1;
        @(negedge clk);
        check("rd_idx1", 32'(rd_data), 32'h0150);
        rd_idx = 2'd0;
        @(negedge clk);
        check("rd_idx0_timeout", 32'(rd_data), 32'hFFFF);
        rd_idx = 2'd3;
        @(negedge clk);
        check("rd_out_of_range", 32'(rd_data), 32'hFFFF);
        repeat (3) @(negedge clk);
        core_ready = 1'b1;
        core_data  = 16'h0300;
        rd_idx     = 2'd1;
        @(negedge clk);
        core_ready = 1'b0;
        check("drop_valid", 32'(result_valid), 1);
        check("drop_idx", 32'(result_idx), 1);
        check("drop_data", 32'(result_data), 32'h0300);
        check("rd_same_cycle_old", 32'(rd_data), 32'h0150);
`ifdef SONAR_PROX_ALARM_EN
        check("alarm_cleared", 32'(prox_alarm[1]), 0);
`endif
        @(negedge clk);
        check("rd_after_write", 32'(rd_data), 32'h0300);
        wait_idle(30, n);
        check("idle_lat", 32'(n), 10);
        check("idle_sel", 32'(sel), 2);
        seen_get = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (core_get_n !== 1'b1) seen_get = 1'b1;
        end
        check("idle_no_get", 32'(seen_get), 0);

        // Restart from IDLE, then reset during GAP.
        enable = 1'b1;
        wait_get_low(10, n);
        check("restart_get_lat", 32'(n), 2);
        check("restart_sel", 32'(sel), 2);
        repeat (4) @(negedge clk);
        core_ready = 1'b1;
        core_data  = 16'h0123;
        @(negedge clk);
        core_ready = 1'b0;
        check("restart_valid", 32'(result_valid), 1);
        check("restart_idx", 32'(result_idx), 2);
`ifdef SONAR_PROX_ALARM_EN
        check("restart_alarm", 32'(prox_alarm[2]), 1);
`endif
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_reset("gap_rst");
        reset  = 1'b1;
        rd_idx = 2'd2;
        @(negedge clk);
        check("tbl_cleared2", 32'(rd_data), 32'hFFFF);
        check("post_rst_core_rst", 32'(core_rst_n), 1);
        check("post_rst_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
